// File: rtl/mem_interface.sv
// Memory-access sequencer: turns CPU read/write requests into a wait-state
// handshake with word-addressed memory, bounded by a timeout.
module mem_interface #(
    parameter int unsigned REG_SIZE  = 32,
    parameter int unsigned ADDR_BITS = 9,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rd_req,
    input  logic                 wr_req,
    input  logic [REG_SIZE-1:0]  addr,
    input  logic [REG_SIZE-1:0]  wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [REG_SIZE-1:0]  mem_wdata,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic [REG_SIZE-1:0]  mem_rdata,
    input  logic                 mem_ready,
    output logic [REG_SIZE-1:0]  m_data_in,
    output logic                 mdr_in,
    output logic                 md_mux_select
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_WR_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    state_t                r_state, w_next_state;
    logic [7:0]            r_cnt, w_cnt_next;
    logic                  r_rd_txn, w_rd_txn_next;
    logic [ADDR_BITS-1:0]  r_mem_addr, w_mem_addr_next;
    logic [REG_SIZE-1:0]   r_mem_wdata, w_mem_wdata_next;
    logic [REG_SIZE-1:0]   r_m_data_in, w_m_data_in_next;
    logic                  r_mem_read, w_mem_read_next;
    logic                  r_mem_write, w_mem_write_next;
    logic                  r_busy, w_busy_next;
    logic                  r_done, w_done_next;
    logic                  r_err, w_err_next;
    logic                  r_mdr, w_mdr_next;
    logic                  w_unused_addr_hi;

    assign w_unused_addr_hi = ^addr[REG_SIZE-1:ADDR_BITS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rd_txn    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_m_data_in <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mdr       <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_cnt_next;
            r_rd_txn    <= w_rd_txn_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_m_data_in <= w_m_data_in_next;
            r_mem_read  <= w_mem_read_next;
            r_mem_write <= w_mem_write_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_err       <= w_err_next;
            r_mdr       <= w_mdr_next;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_cnt_next       = r_cnt;
        w_rd_txn_next    = r_rd_txn;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_m_data_in_next = r_m_data_in;
        w_mem_read_next  = r_mem_read;
        w_mem_write_next = r_mem_write;
        w_done_next      = 1'b0;
        w_err_next       = 1'b0;
        w_mdr_next       = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Read has priority; a simultaneous write is dropped.
                if (rd_req) begin
                    w_next_state    = S_RD_WAIT;
                    w_mem_addr_next = addr[ADDR_BITS-1:0];
                    w_mem_read_next = 1'b1;
                    w_cnt_next      = '0;
                    w_rd_txn_next   = 1'b1;
                end else if (wr_req) begin
                    w_next_state     = S_WR_WAIT;
                    w_mem_addr_next  = addr[ADDR_BITS-1:0];
                    w_mem_wdata_next = wr_data;
                    w_mem_write_next = 1'b1;
                    w_cnt_next       = '0;
                    w_rd_txn_next    = 1'b0;
                end
            end
            S_RD_WAIT: begin
                if (mem_ready) begin
                    w_m_data_in_next = mem_rdata;
                    w_mem_read_next  = 1'b0;
                    w_next_state     = S_DONE;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_mem_read_next = 1'b0;
                    w_next_state    = S_ERR;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            S_WR_WAIT: begin
                if (mem_ready) begin
                    w_mem_write_next = 1'b0;
                    w_next_state     = S_DONE;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_mem_write_next = 1'b0;
                    w_next_state     = S_ERR;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            S_DONE: begin
                w_done_next  = 1'b1;
                w_mdr_next   = r_rd_txn;
                w_next_state = S_IDLE;
            end
            S_ERR: begin
                w_done_next  = 1'b1;
                w_err_next   = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase

        // Busy stays up through the registered done/err pulse cycle.
        w_busy_next = (w_next_state != S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_read      = r_mem_read;
    assign mem_write     = r_mem_write;
    assign m_data_in     = r_m_data_in;
    assign mdr_in        = r_mdr;
    assign md_mux_select = r_mdr;

endmodule

// File: tb/tb_mem_interface.sv
// Randomized bench for mem_interface: a transaction-timeline model predicts
// every output each cycle; directed items pin the model with literal values.
module tb_mem_interface;

    localparam int unsigned RS = 32;
    localparam int unsigned AB = 9;
    localparam int unsigned TO = 15;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          rd_req = 1'b0;
    logic          wr_req = 1'b0;
    logic          mem_ready = 1'b0;
    logic [RS-1:0] addr = '0;
    logic [RS-1:0] wr_data = '0;
    logic [RS-1:0] mem_rdata = '0;
    logic          busy, done, err, mem_read, mem_write, mdr_in, md_mux_select;
    logic [AB-1:0] mem_addr;
    logic [RS-1:0] mem_wdata, m_data_in;

    mem_interface #(.REG_SIZE(RS), .ADDR_BITS(AB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .wr_req(wr_req),
        .addr(addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .m_data_in(m_data_in), .mdr_in(mdr_in), .md_mux_select(md_mux_select)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 read, 1 write, 2 both
        logic [31:0] ad;
        logic [31:0] wd;
        logic [31:0] rdw;
        int          w;      // wait cycles before ready; >= TO means never
        bit          lit;
        logic [8:0]  ladr;
        int          len;
        logic [31:0] word;
        bit          lerr;
    } item_t;

    item_t         dq[$];
    item_t         cur;
    bit            act = 0, t_rd = 0, t_ok = 0, lit_valid = 0, fix_rd = 0, no_new = 0;
    int            t_a = 0, t_len = 0, t_w = 0;
    logic [31:0]   fix_rdw = '0;
    logic [AB-1:0] pend_addr = '0, exp_addr = '0;
    logic [RS-1:0] pend_wdata = '0, exp_wdata = '0, exp_mdata = '0, rd_word = '0;
    int            total = 0, bad = 0, strb = 0;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, got, want, cyc);
        end
    endfunction

    always @(negedge clk) begin : cmp
        int n;
        bit win, de;
        if (!reset_n) begin
            exp_addr  = '0;
            exp_wdata = '0;
            exp_mdata = '0;
            strb      = 0;
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_err", 32'(err), 0);
            chk("rst_mem_read", 32'(mem_read), 0);
            chk("rst_mem_write", 32'(mem_write), 0);
            chk("rst_mdr_in", 32'(mdr_in), 0);
            chk("rst_md_mux", 32'(md_mux_select), 0);
            chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_m_data_in", m_data_in, 0);
        end else begin
            n = cyc;
            if (act && n == t_a) begin
                exp_addr = pend_addr;
                if (!t_rd) exp_wdata = pend_wdata;
                strb = 0;
            end
            if (act && t_ok && t_rd && n == t_a + t_len) exp_mdata = rd_word;
            win = act && n >= t_a && n < t_a + t_len;
            de  = act && n == t_a + t_len + 1;
            if (mem_read === 1'b1 || mem_write === 1'b1) strb++;
            chk("busy", 32'(busy), 32'(act && n >= t_a && n <= t_a + t_len + 1));
            chk("mem_read", 32'(mem_read), 32'(win && t_rd));
            chk("mem_write", 32'(mem_write), 32'(win && !t_rd));
            chk("done", 32'(done), 32'(de));
            chk("err", 32'(err), 32'(de && !t_ok));
            chk("mdr_in", 32'(mdr_in), 32'(de && t_ok && t_rd));
            chk("md_mux_select", 32'(md_mux_select), 32'(de && t_ok && t_rd));
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            chk("mem_wdata", mem_wdata, exp_wdata);
            chk("m_data_in", m_data_in, exp_mdata);
            if (de && lit_valid) begin
                chk("lit_strobe_len", 32'(strb), 32'(cur.len));
                chk("lit_word", m_data_in, cur.word);
                chk("lit_model_word", exp_mdata, cur.word);
                chk("lit_err", 32'(err), 32'(cur.lerr));
                chk("lit_addr", 32'(mem_addr), 32'(cur.ladr));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Prepares inputs for the coming rising edge e = cyc + 1.
    task automatic drive();
        int e;
        bit idle_e, rq_rd, rq_wr;
        int r;
        e = cyc + 1;
        idle_e = !act || (e >= t_a + t_len + 2);
        addr      = $urandom;
        wr_data   = $urandom;
        mem_rdata = $urandom;
        mem_ready = 1'($urandom_range(0, 1));
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        if (idle_e) begin
            rq_rd = 0;
            rq_wr = 0;
            if (dq.size() > 0) begin
                cur       = dq.pop_front();
                rq_rd     = (cur.kind != 1);
                rq_wr     = (cur.kind != 0);
                addr      = cur.ad;
                wr_data   = cur.wd;
                t_w       = cur.w;
                fix_rd    = 1;
                fix_rdw   = cur.rdw;
                lit_valid = cur.lit;
            end else if (!no_new) begin
                r     = int'($urandom_range(0, 9));
                rq_rd = (r <= 3) || (r == 8);
                rq_wr = (r >= 4) && (r <= 8);
                t_w   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO + 3))
                                                    : int'($urandom_range(0, 3));
                fix_rd    = 0;
                lit_valid = 0;
            end
            rd_req = rq_rd;
            wr_req = rq_wr;
            if (rq_rd || rq_wr) begin
                act        = 1;
                t_a        = e;
                t_rd       = rq_rd;
                t_ok       = (t_w + 1 <= int'(TO));
                t_len      = t_ok ? t_w + 1 : int'(TO);
                pend_addr  = addr[AB-1:0];
                pend_wdata = wr_data;
            end
        end else begin
            rd_req = 1'($urandom_range(0, 1));
            wr_req = 1'($urandom_range(0, 1));
            if (e >= t_a + 1 && e <= t_a + t_len) mem_ready = t_ok && (e == t_a + t_w + 1);
            if (t_ok && e == t_a + t_len) begin
                if (fix_rd) mem_rdata = fix_rdw;
                rd_word = mem_rdata;
            end
        end
    endtask

    function automatic item_t mk(input int kind, input logic [31:0] ad, input logic [31:0] wd,
                                 input logic [31:0] rdw, input int w, input bit lit,
                                 input logic [8:0] ladr, input int len, input logic [31:0] word,
                                 input bit lerr);
        item_t it;
        it.kind = kind; it.ad = ad; it.wd = wd; it.rdw = rdw; it.w = w; it.lit = lit;
        it.ladr = ladr; it.len = len; it.word = word; it.lerr = lerr;
        return it;
    endfunction

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (2) step();

        // Read that never completes, killed by an asynchronous reset mid-wait.
        dq.push_back(mk(0, 32'h0000_01F0, 32'h0, 32'h0, 99, 0, 9'h0, 0, 32'h0, 0));
        repeat (7) begin step(); drive(); end
        @(posedge clk);
        #2;
        reset_n   = 1'b0;
        act       = 0;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        mem_ready = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (4) step();

        dq.push_back(mk(0, 32'h0000_0123, 32'h0, 32'hDEAD_BEEF, 0, 1, 9'h123, 1, 32'hDEAD_BEEF, 0));
        dq.push_back(mk(1, 32'h0000_01FF, 32'h0000_00A5, 32'h0, 3, 1, 9'h1FF, 4, 32'hDEAD_BEEF, 0));
        dq.push_back(mk(0, 32'h0000_0055, 32'h0, 32'h0, 99, 1, 9'h055, 15, 32'hDEAD_BEEF, 1));
        dq.push_back(mk(2, 32'h0000_00AA, 32'h0000_1111, 32'hCAFE_F00D, 1, 1, 9'h0AA, 2, 32'hCAFE_F00D, 0));
        dq.push_back(mk(1, 32'h0000_0100, 32'h0000_0001, 32'h0, 0, 1, 9'h100, 1, 32'hCAFE_F00D, 0));
        dq.push_back(mk(0, 32'h8000_0277, 32'h0, 32'h1234_5678, 14, 1, 9'h077, 15, 32'h1234_5678, 0));

        repeat (3000) begin step(); drive(); end
        no_new = 1;
        repeat (TO + 6) begin step(); drive(); end
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_interface.md
Name: mem_interface

Overview:
Memory-access sequencer between the CPU datapath and external word-addressed memory. Takes read/write requests addressed by MAR and sends write data from the MDR output. Runs a wait-state handshake with memory and bounds it with a timeout. On a completed read, returns the memory word on m_data_in and pulses the MDR load controls (mdr_in, md_mux_select) for exactly one cycle.

Parameters:
REG_SIZE, 32, datapath/memory word width in bits
ADDR_BITS, 9, memory address width; mem_addr = addr[ADDR_BITS-1:0]
TIMEOUT, 15, max cycles in a wait state without mem_ready before abort (1..255)

Ports:
clk  in  1  system clock, rising-edge
reset_n  in  1  asynchronous active-low reset
rd_req  in  1  read request, sampled only in IDLE
wr_req  in  1  write request, sampled only in IDLE
addr  in  REG_SIZE  address from MAR output
wr_data  in  REG_SIZE  write data from MDR output
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at end of any transaction (success or abort)
err  out  1  one-cycle pulse, coincident with done, on timeout abort
mem_addr  out  ADDR_BITS  latched memory address
mem_wdata  out  REG_SIZE  latched write data
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_rdata  in  REG_SIZE  memory read data, valid when mem_ready=1
mem_ready  in  1  memory completion acknowledge
m_data_in  out  REG_SIZE  registered read word to MDR input mux
mdr_in  out  1  MDR load enable, one-cycle pulse
md_mux_select  out  1  MDR mux select (1 = memory), one-cycle pulse with mdr_in

Behaviour:
- All outputs are registered (Moore). States: IDLE, RD_WAIT, WR_WAIT, DONE, ERR.
- Reset (async, any state): state=IDLE and timeout counter=0. Every output resets to 0, including m_data_in, mem_addr and mem_wdata. A transaction in progress is aborted with no done pulse.
- IDLE, rd_req=1: latch addr[ADDR_BITS-1:0] into mem_addr, set mem_read=1, clear counter, go to RD_WAIT.
- IDLE, wr_req=1 and rd_req=0: latch addr and wr_data, set mem_write=1, clear counter, go to WR_WAIT.
- IDLE, rd_req=wr_req=1: the read wins and the write is dropped (no queuing).
- Requests arriving in any state other than IDLE are ignored. The requester must wait for done before issuing the next one.
- RD_WAIT: mem_read and mem_addr stay stable.
  - mem_ready=1: m_data_in<=mem_rdata, mem_read<=0, go to DONE.
  - mem_ready=0: counter increments. When counter reaches TIMEOUT-1 with mem_ready still 0, drop mem_read and go to ERR.
- WR_WAIT: same as RD_WAIT with mem_write and mem_wdata held stable. On mem_ready=1, drop mem_write and go to DONE. m_data_in is not touched.
- DONE (1 cycle): done=1. If the transaction was a read, mdr_in=1 and md_mux_select=1; for a write both stay 0. Next state IDLE.
- ERR (1 cycle): done=1, err=1. mdr_in, md_mux_select stay 0 and m_data_in keeps its previous value. Next state IDLE.
- Latency:
  - Request sampled at edge E0; strobe is high in cycle E0..E1.
  - mem_ready high at edge E1 (zero wait) gives done in cycle E2..E3.
  - Each extra wait cycle adds 1.
  - Back-to-back throughput: a new request is accepted at the edge that returns to IDLE + 1 cycle, i.e. one idle cycle minimum.
- mem_ready is ignored in IDLE, DONE and ERR.
- mem_ready arriving on the same edge the timeout expires: ready wins and the transaction completes normally.
- busy is high from the cycle after acceptance through the DONE/ERR cycle inclusive.

Test Plan:
- Reset with outputs forced nonzero mid-read -> all outputs 0 immediately (async), state IDLE, no done pulse after release.
- rd_req, addr=0x0000_0123, mem_ready one cycle later with mem_rdata=0xDEADBEEF -> mem_addr=0x123, mem_read high 1 cycle; m_data_in=0xDEADBEEF; mdr_in=md_mux_select=done=1 for exactly 1 cycle 2 cycles after acceptance.
- wr_req, addr=0x1FF, wr_data=0x0000_00A5, 3 wait cycles -> mem_write high 4 cycles with mem_wdata=0xA5 stable; done 1 cycle; mdr_in stays 0; m_data_in unchanged.
- rd_req with mem_ready never asserted, TIMEOUT=15 -> mem_read high exactly 15 cycles, then done=err=1 for 1 cycle, mdr_in=0, m_data_in unchanged.
- rd_req and wr_req together, then wr_req pulsed while busy -> only the read executes, mem_write never asserts; the subsequent wr_req after return to IDLE is accepted.
- mem_ready first asserted on the 15th wait cycle (timeout edge) with mem_rdata=0x12345678 -> normal completion: done=1, err=0, m_data_in=0x12345678.
